core_sequencer: RTL and testbench

- Multi-cycle control FSM for the single-issue core.
- Sequences fetch, decode, execute, memory and writeback over one shared memory port.
- Consumes the instruction decoder's control outputs and drives datapath strobes: IR load, PC increment, register-file write, address and writeback muxes.
- Counts retired instructions and traps sticky on an illegal instruction or a memory-port timeout.

---
 rtl/isa_shared_pkg.sv | 40 ++++
 rtl/core_sequencer_bus_watchdog.sv | 29 ++
 rtl/core_sequencer.sv | 125 ++++++++++++
 tb/tb_core_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_shared_pkg.sv
// rtl/isa_shared_pkg.sv - shared ISA encodings and control-sequencer types
package isa_shared;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5,
    ALU_SLT = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NOP  = 3'd0,
    IMM_3120 = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_op_t;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_ILLEGAL = 2'd1,
    TRAP_BUS     = 2'd2
  } trap_cause_t;

endpackage

// File: rtl/core_sequencer_bus_watchdog.sv
// rtl/core_sequencer_bus_watchdog.sv - memory-request timeout counter
// timeout fires on the MEM_TIMEOUT-th unanswered cycle of one request; 0 disables it.
module bus_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (active && !ready) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && active && !ready &&
                   (r_count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback control FSM
// Strobes decode from the registered state; only ir_load looks at mem_ready directly.
module core_sequencer
  import isa_shared::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               dec_alu_op,
  input  logic [2:0]               dec_imm_op,
  input  logic                     dec_mem_read,
  input  logic                     dec_mem_write,
  input  logic                     dec_reg_write,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_sel,
  output logic                     ir_load,
  output logic                     pc_inc,
  output logic                     rf_we,
  output logic                     wb_sel,
  output logic                     halted,
  output logic [1:0]               trap_cause,
  output logic [2:0]               state,
  output logic [INSTRET_WIDTH-1:0] instret
);

  ctrl_state_t              r_state;
  ctrl_state_t              w_next;
  trap_cause_t              r_trap_cause;
  trap_cause_t              w_cause_next;
  logic [INSTRET_WIDTH-1:0] r_instret;
  logic                     w_wd_active;
  logic                     w_wd_clear;
  logic                     w_timeout;

  assign w_wd_active = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wd_clear  = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);

  bus_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_wd_clear),
    .active (w_wd_active),
    .ready  (mem_ready),
    .timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RESET;
      r_trap_cause <= TRAP_NONE;
      r_instret    <= '0;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_cause_next;
      if (r_state == S_WRITEBACK) begin
        r_instret <= r_instret + INSTRET_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_trap_cause;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_inc       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = TRAP_BUS;
        end
      end
      S_DECODE: begin
        if ((dec_alu_op == ALU_NOP && dec_imm_op == IMM_NOP) ||
            (dec_mem_read && dec_mem_write)) begin
          w_next       = S_TRAP;
          w_cause_next = TRAP_ILLEGAL;
        end else begin
          w_next = S_EXECUTE;
        end
      end
      S_EXECUTE: w_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WRITEBACK;
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_write;
        if (mem_ready) begin
          w_next = S_WRITEBACK;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = TRAP_BUS;
        end
      end
      S_WRITEBACK: begin
        rf_we  = dec_reg_write;
        wb_sel = dec_mem_read;
        pc_inc = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  halted = 1'b1;
      default: w_next = S_RESET;
    endcase
  end

  assign ir_load    = mem_ready && (r_state == S_FETCH);
  assign trap_cause = r_trap_cause;
  assign state      = r_state;
  assign instret    = r_instret;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;
  import isa_shared::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dec_alu_op;
  logic [2:0] dec_imm_op;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_reg_write;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       rf_we;
  logic       wb_sel;
  logic       halted;
  logic [1:0] trap_cause;
  logic [2:0] state;
  logic [3:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  core_sequencer #(
    .MEM_TIMEOUT  (8),
    .INSTRET_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_alu_op   (dec_alu_op),
    .dec_imm_op   (dec_imm_op),
    .dec_mem_read (dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .trap_cause   (trap_cause),
    .state        (state),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [2:0] alu, input logic [2:0] imm,
                           input logic rd, input logic wr, input logic rw);
    dec_alu_op    = alu;
    dec_imm_op    = imm;
    dec_mem_read  = rd;
    dec_mem_write = wr;
    dec_reg_write = rw;
  endtask

  initial begin
    int cnt;
    int guard;
    logic stable_ok;

    rst       = 1'b1;
    mem_ready = 1'b1;
    set_instr(ALU_ADD, IMM_3120, 1'b1, 1'b0, 1'b1);
    tick();
    chk("reset_state", 32'(state), 32'(S_RESET));
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_ir_load", 32'(ir_load), 0);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_cause", 32'(trap_cause), 32'(TRAP_NONE));
    chk("reset_instret", 32'(instret), 0);
    chk("reset_strobes", {29'd0, rf_we, pc_inc, wb_sel}, 0);

    // zero-wait load
    rst = 1'b0;
    tick();
    chk("lw_fetch_state", 32'(state), 32'(S_FETCH));
    chk("lw_fetch_req", {30'd0, mem_req, mem_addr_sel}, 32'b10);
    chk("lw_fetch_ir_load", 32'(ir_load), 1);
    tick();
    chk("lw_decode_state", 32'(state), 32'(S_DECODE));
    tick();
    chk("lw_exec_state", 32'(state), 32'(S_EXECUTE));
    chk("lw_exec_no_req", 32'(mem_req), 0);
    tick();
    chk("lw_mem_state", 32'(state), 32'(S_MEM));
    chk("lw_mem_req_sel_we", {29'd0, mem_req, mem_addr_sel, mem_we}, 32'b110);
    tick();
    chk("lw_wb_state", 32'(state), 32'(S_WRITEBACK));
    chk("lw_wb_rf_wb_pc", {29'd0, rf_we, wb_sel, pc_inc}, 32'b111);
    chk("lw_wb_no_req", 32'(mem_req), 0);
    tick();
    chk("lw_next_fetch", 32'(state), 32'(S_FETCH));
    chk("lw_instret", 32'(instret), 1);

    // fetch with three wait states, then an ALU-only instruction
    set_instr(ALU_ADD, IMM_NOP, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      mem_ready = (n == 4);
      #1;
      chk("fw_state", 32'(state), 32'(S_FETCH));
      chk("fw_req_sel", {30'd0, mem_req, mem_addr_sel}, 32'b10);
      chk("fw_ir_load", 32'(ir_load), (n == 4) ? 1 : 0);
      tick();
    end
    chk("fw_decode", 32'(state), 32'(S_DECODE));
    tick();
    tick();
    chk("add_wb_state", 32'(state), 32'(S_WRITEBACK));
    chk("add_wb_rf_wb_pc", {29'd0, rf_we, wb_sel, pc_inc}, 32'b101);
    tick();
    chk("add_instret", 32'(instret), 2);

    // mem_ready on the 8th (last allowed) fetch cycle still wins
    for (int n = 1; n <= 8; n++) begin
      mem_ready = (n == 8);
      #1;
      chk("late_fetch_state", 32'(state), 32'(S_FETCH));
      tick();
    end
    chk("late_decode", 32'(state), 32'(S_DECODE));
    chk("late_no_trap", 32'(trap_cause), 32'(TRAP_NONE));
    tick();
    tick();
    tick();
    chk("late_instret", 32'(instret), 3);

    // store whose memory phase never completes
    set_instr(ALU_ADD, IMM_S, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("sw_mem_state", 32'(state), 32'(S_MEM));
    mem_ready = 1'b0;
    cnt = 0;
    guard = 0;
    stable_ok = 1'b1;
    while (state == S_MEM && guard < 20) begin
      cnt += int'(mem_req);
      if (!(mem_we && mem_addr_sel)) stable_ok = 1'b0;
      guard++;
      tick();
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_we_sel_stable", 32'(stable_ok), 1);
    chk("to_state", 32'(state), 32'(S_TRAP));
    chk("to_cause", 32'(trap_cause), 32'(TRAP_BUS));
    chk("to_halted_req", {30'd0, halted, mem_req}, 32'b10);
    chk("to_instret", 32'(instret), 3);

    // reset out of TRAP, retire one store, then reset mid-access
    rst = 1'b1;
    tick();
    chk("rst_trap_state", 32'(state), 32'(S_RESET));
    chk("rst_trap_cause", 32'(trap_cause), 32'(TRAP_NONE));
    chk("rst_trap_halted", 32'(halted), 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    chk("sw_retired", 32'(instret), 1);
    tick();
    tick();
    tick();
    chk("mid_mem_req", {30'd0, mem_req, mem_we}, 32'b11);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", 32'(state), 32'(S_RESET));
    chk("mid_rst_strobes", {25'd0, mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, rf_we, wb_sel}, 0);
    chk("mid_rst_instret", 32'(instret), 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_fetch", 32'(state), 32'(S_FETCH));

    // illegal: no ALU and no immediate op
    set_instr(ALU_NOP, IMM_NOP, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ill_decode", 32'(state), 32'(S_DECODE));
    tick();
    chk("ill_state", 32'(state), 32'(S_TRAP));
    chk("ill_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));
    chk("ill_instret", 32'(instret), 0);
    for (int n = 0; n < 20; n++) begin
      chk("ill_hold", {26'd0, state, halted, rf_we, pc_inc}, {26'd0, 3'(S_TRAP), 3'b100});
      tick();
    end

    // illegal: load and store at once
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_instr(ALU_ADD, IMM_S, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("ldst_state", 32'(state), 32'(S_TRAP));
    chk("ldst_cause", 32'(trap_cause), 32'(TRAP_ILLEGAL));

    // 4-bit retired counter wraps after 16 ALU instructions
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_instr(ALU_SUB, IMM_NOP, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 1; k <= 17; k++) begin
      tick();
      tick();
      tick();
      tick();
      chk("wrap_state", 32'(state), 32'(S_FETCH));
      chk("wrap_instret", 32'(instret), k % 16);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
